sdbp_frame_rx: RTL and testbench

- Receiving end of the sdbpflag/wtaddr/wtdina LED write stream.
- Captures one frame of N_LED 16-bit brightness words into a ping-pong buffer. On frame completion it swaps banks and shifts the frame out serially to the LED driver chain (sclk/sdi/lat).
- Sits between the zone-backlight brightness generator and the MiniLED driver pins, in the 25 MHz clk domain.

---
 rtl/sdbp_frame_rx.sv | 244 ++++++++++++++++++++++++
 tb/tb_sdbp_frame_rx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdbp_frame_rx.sv
// sdbpflag/wtaddr/wtdina frame receiver: ping-pong capture plus serial shift-out to the LED drivers.
// Optional watchdog blanking is compiled in with `define SDBP_RX_WDOG_EN.
module sdbp_frame_rx #(
    parameter int N_LED     = 360,
    parameter int AW        = 10,
    parameter int DW        = 16,
    parameter int SCLK_HALF = 2,
    parameter int LAT_CYC   = 4,
    parameter int WDOG_CYC  = 1_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sdbpflag,
    input  logic [AW-1:0] wtaddr,
    input  logic [DW-1:0] wtdina,
    output logic          drv_sclk,
    output logic          drv_sdi,
    output logic          drv_lat,
    output logic          busy,
    output logic          frame_ok,
    output logic          frame_err,
    output logic          overrun
);

    localparam int RAW = $clog2(2 * N_LED);
    localparam int IW  = $clog2(N_LED);
    localparam int BW  = $clog2(DW);
    localparam int HW  = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int LW  = (LAT_CYC > 1) ? $clog2(LAT_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_LAT} state_t;

    // capture side
    logic          flag_q;
    logic          active_q;
    logic [AW-1:0] exp_addr_q;
    logic          wbank_q;
    logic          frame_ok_q;
    logic          frame_err_q;
    logic          overrun_q;
    logic          start_q;
    logic          blank_q;

    // serializer side
    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic [DW-1:0] shreg_q;
    logic [BW-1:0] bit_q;
    logic [HW-1:0] half_q;
    logic [LW-1:0] lat_cnt_q;
    logic          sclk_q;
    logic          sdi_q;
    logic          lat_q;
    logic          busy_q;

    logic [DW-1:0] mem [0:2*N_LED-1];
    logic [DW-1:0] rdata_q;

    logic          rise;
    logic          wr_hit;
    logic          last_hit;
    logic          ser_idle;
    logic          bit_end;
    logic          rd_en;
    logic [IW-1:0] rd_idx;
    logic [RAW-1:0] wr_ptr;
    logic [RAW-1:0] rd_ptr;
    logic [DW-1:0] load_word;

    assign rise      = sdbpflag & ~flag_q;
    assign wr_hit    = active_q && (wtaddr == exp_addr_q);
    assign last_hit  = wr_hit && (exp_addr_q == AW'(N_LED));
    // a start already queued for next cycle counts as busy
    assign ser_idle  = (state_q == S_IDLE) && !start_q;
    assign bit_end   = (state_q == S_SHIFT) && sclk_q && (half_q == HW'(SCLK_HALF - 1))
                       && (bit_q == BW'(DW - 1));
    assign load_word = blank_q ? '0 : rdata_q;

    assign wr_ptr = (wbank_q ? RAW'(N_LED) : RAW'(0)) + RAW'(exp_addr_q - 1'b1);
    assign rd_ptr = (wbank_q ? RAW'(0) : RAW'(N_LED)) + RAW'(rd_idx);

    // Read is issued on the edge that enters LOAD so the word is ready during LOAD.
    always_comb begin
        rd_en  = 1'b0;
        rd_idx = idx_q + 1'b1;
        if (state_q == S_IDLE && start_q) begin
            rd_en  = 1'b1;
            rd_idx = '0;
        end else if (bit_end && idx_q != IW'(N_LED - 1)) begin
            rd_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_hit) begin
            mem[wr_ptr] <= wtdina;
        end
        if (rd_en) begin
            rdata_q <= mem[rd_ptr];
        end
    end

`ifdef SDBP_RX_WDOG_EN
    localparam int WDW = $clog2(WDOG_CYC + 1);
    logic [WDW-1:0] wdog_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q      <= 1'b0;
            active_q    <= 1'b0;
            exp_addr_q  <= AW'(1);
            wbank_q     <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            start_q     <= 1'b0;
            blank_q     <= 1'b0;
`ifdef SDBP_RX_WDOG_EN
            wdog_q      <= '0;
`endif
        end else begin
            flag_q      <= sdbpflag;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            start_q     <= 1'b0;
            if (wr_hit) begin
                exp_addr_q <= exp_addr_q + 1'b1;
            end
            if (last_hit) begin
                active_q <= 1'b0;
                if (ser_idle) begin
                    wbank_q    <= ~wbank_q;
                    frame_ok_q <= 1'b1;
                    start_q    <= 1'b1;
                    blank_q    <= 1'b0;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
            // a rise coinciding with the final write opens the next frame cleanly
            if (rise) begin
                if (active_q && !last_hit) begin
                    frame_err_q <= 1'b1;
                end
                active_q   <= 1'b1;
                exp_addr_q <= AW'(1);
            end
`ifdef SDBP_RX_WDOG_EN
            if (last_hit && ser_idle) begin
                wdog_q <= '0;
            end else if (wdog_q == WDW'(WDOG_CYC)) begin
                if (ser_idle) begin
                    start_q <= 1'b1;
                    blank_q <= 1'b1;
                    wdog_q  <= '0;
                end
            end else begin
                wdog_q <= wdog_q + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            shreg_q   <= '0;
            bit_q     <= '0;
            half_q    <= '0;
            lat_cnt_q <= '0;
            sclk_q    <= 1'b0;
            sdi_q     <= 1'b0;
            lat_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_q) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                    end
                end
                S_LOAD: begin
                    shreg_q <= load_word;
                    sdi_q   <= load_word[DW-1];
                    sclk_q  <= 1'b0;
                    half_q  <= '0;
                    bit_q   <= '0;
                    state_q <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (half_q == HW'(SCLK_HALF - 1)) begin
                        half_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_q == BW'(DW - 1)) begin
                                if (idx_q != IW'(N_LED - 1)) begin
                                    idx_q   <= idx_q + 1'b1;
                                    state_q <= S_LOAD;
                                end else begin
                                    state_q   <= S_LAT;
                                    lat_q     <= 1'b1;
                                    sdi_q     <= 1'b0;
                                    lat_cnt_q <= '0;
                                end
                            end else begin
                                bit_q   <= bit_q + 1'b1;
                                shreg_q <= {shreg_q[DW-2:0], 1'b0};
                                sdi_q   <= shreg_q[DW-2];
                            end
                        end
                    end else begin
                        half_q <= half_q + 1'b1;
                    end
                end
                S_LAT: begin
                    if (lat_cnt_q == LW'(LAT_CYC - 1)) begin
                        state_q <= S_IDLE;
                        lat_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign drv_sclk  = sclk_q;
    assign drv_sdi   = sdi_q;
    assign drv_lat   = lat_q;
    assign busy      = busy_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sdbp_frame_rx.sv
// Directed bench for sdbp_frame_rx: frame capture, error/overrun paths, async reset mid-shift.
`timescale 1ns/1ps
module tb_sdbp_frame_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sdbpflag = 1'b0;
    logic [9:0]  wtaddr = '0;
    logic [15:0] wtdina = '0;
    logic        drv_sclk, drv_sdi, drv_lat, busy, frame_ok, frame_err, overrun;

    int vec_cnt = 0;
    int miss_cnt = 0;

    // wire monitor (written only by the monitor process)
    logic [15:0] cap_w [0:2047];
    int          cap_cnt = 0;
    int          bit_cnt = 0;
    logic [15:0] sh = '0;
    logic        sclk_prev = 1'b0;
    int          lat_run = 0;
    int          lat_last = 0;
    int          ok_seen = 0;
    int          err_seen = 0;
    int          ovr_seen = 0;

    sdbp_frame_rx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sdbpflag (sdbpflag),
        .wtaddr   (wtaddr),
        .wtdina   (wtdina),
        .drv_sclk (drv_sclk),
        .drv_sdi  (drv_sdi),
        .drv_lat  (drv_lat),
        .busy     (busy),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #20 clk = ~clk;

    always @(negedge clk) begin
        if (!rst_n) begin
            bit_cnt   = 0;
            sclk_prev = 1'b0;
            lat_run   = 0;
        end else begin
            if (drv_sclk && !sclk_prev) begin
                sh = {sh[14:0], drv_sdi};
                bit_cnt++;
                if (bit_cnt == 16) begin
                    cap_w[cap_cnt] = sh;
                    cap_cnt++;
                    bit_cnt = 0;
                end
            end
            sclk_prev = drv_sclk;
            if (drv_lat) lat_run++;
            else if (lat_run != 0) begin
                lat_last = lat_run;
                lat_run  = 0;
            end
            if (frame_ok)  ok_seen++;
            if (frame_err) err_seen++;
            if (overrun)   ovr_seen++;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input int kind, input int a);
        case (kind)
            0:       return 16'(a * 100);
            1:       return 16'(a * 7 + 1);
            2:       return 16'(32'h1000 + a);
            3:       return 16'(a * 181) ^ 16'hA5A5;
            default: return 16'h7777;
        endcase
    endfunction

    task automatic put(input logic f, input int a, input logic [15:0] d);
        sdbpflag = f;
        wtaddr   = 10'(a);
        wtdina   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic write_run(input int first, input int last, input int kind);
        for (int a = first; a <= last; a++) put(1'b0, a, word_of(kind, a));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 40000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_value(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_words(input string tag, input int base, input int n, input int kind);
        for (int i = 0; i < n; i++)
            check_value($sformatf("%s_led%0d", tag, i + 1), 32'(cap_w[base + i]), 32'(word_of(kind, i + 1)));
    endtask

    task automatic check_outputs_zero(input string tag);
        check_value({tag, "_sclk"}, 32'(drv_sclk), 32'd0);
        check_value({tag, "_sdi"},  32'(drv_sdi),  32'd0);
        check_value({tag, "_lat"},  32'(drv_lat),  32'd0);
        check_value({tag, "_busy"}, 32'(busy),     32'd0);
        check_value({tag, "_ok"},   32'(frame_ok), 32'd0);
        check_value({tag, "_err"},  32'(frame_err),32'd0);
        check_value({tag, "_ovr"},  32'(overrun),  32'd0);
    endtask

    initial begin
        int base;
        int n;

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        put(1'b0, 0, 16'h0);

        // Frame A: addr*100, then frame B arrives while A is shifting
        base = cap_cnt;
        put(1'b1, 0, 16'h0);
        write_run(1, 360, 0);
        check_value("A_frame_ok", 32'(frame_ok), 32'd1);
        put(1'b0, 0, 16'h0);
        check_value("A_ok_one_cycle", 32'(frame_ok), 32'd0);
        check_value("A_busy_load", 32'(busy), 32'd1);

        put(1'b1, 0, 16'h0);
        write_run(1, 360, 1);
        check_value("B_overrun", 32'(overrun), 32'd1);
        check_value("B_no_ok", 32'(frame_ok), 32'd0);
        put(1'b0, 0, 16'h0);
        check_value("B_ovr_one_cycle", 32'(overrun), 32'd0);

        wait_idle("A_busy_done");
        put(1'b0, 0, 16'h0);
        check_value("A_lat_len", 32'(lat_last), 32'd4);
        check_value("A_word_count", 32'(cap_cnt - base), 32'd360);
        check_value("A_first_word", 32'(cap_w[base]), 32'h0064);
        check_value("A_last_word", 32'(cap_w[base + 359]), 32'h8CA0);
        check_words("A", base, 360, 0);
        check_value("A_ok_count", 32'(ok_seen), 32'd1);

        // Abandoned frame at addr 200; the second rise opens frame J
        base = cap_cnt;
        put(1'b1, 0, 16'h0);
        put(1'b0, 0, 16'h0);
        write_run(1, 200, 4);
        put(1'b0, 0, 16'h0);
        put(1'b1, 0, 16'h0);
        check_value("err200_frame_err", 32'(frame_err), 32'd1);
        check_value("err200_no_ok", 32'(frame_ok), 32'd0);
        put(1'b0, 0, 16'hFFFF);
        check_value("err200_err_one_cycle", 32'(frame_err), 32'd0);
        check_value("err200_sclk_idle", 32'(drv_sclk), 32'd0);
        check_value("err200_sdi_idle", 32'(drv_sdi), 32'd0);
        check_value("err200_busy_idle", 32'(busy), 32'd0);
        check_value("err200_no_bits", 32'(cap_cnt - base), 32'd0);

        // Frame J: junk prefix, final write coincides with a new rise
        put(1'b0, 1, 16'h1001);
        put(1'b0, 1, 16'hDEAD);
        put(1'b0, 2, 16'h1002);
        put(1'b0, 5, 16'hBEEF);
        write_run(3, 359, 2);
        put(1'b1, 360, word_of(2, 360));
        check_value("J_frame_ok", 32'(frame_ok), 32'd1);
        check_value("J_simul_no_err", 32'(frame_err), 32'd0);
        put(1'b0, 0, 16'h0);
        check_value("J_simul_no_err2", 32'(frame_err), 32'd0);

        n = 0;
        while (cap_cnt < base + 99 && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_value("J_reach_led100", 32'(cap_cnt >= base + 99), 32'd1);
        check_value("J_busy_mid", 32'(busy), 32'd1);
        #5;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        check_words("J", base, 99, 2);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        put(1'b0, 0, 16'h0);

        // Stall at exp 4, then frame F from the rise that reports the error
        base = cap_cnt;
        put(1'b1, 0, 16'h0);
        put(1'b0, 0, 16'h0);
        put(1'b0, 1, 16'h1111);
        put(1'b0, 1, 16'h2222);
        put(1'b0, 2, 16'h3333);
        put(1'b0, 5, 16'h5555);
        put(1'b0, 3, 16'h4444);
        put(1'b0, 6, 16'h6666);
        put(1'b0, 7, 16'h7777);
        put(1'b1, 0, 16'h0);
        check_value("stall_frame_err", 32'(frame_err), 32'd1);
        put(1'b0, 0, 16'h0);
        write_run(1, 359, 3);
        check_value("F_no_early_ok", 32'(frame_ok), 32'd0);
        put(1'b0, 360, word_of(3, 360));
        check_value("F_frame_ok", 32'(frame_ok), 32'd1);
        put(1'b0, 0, 16'h0);
        check_value("F_busy_load", 32'(busy), 32'd1);
        wait_idle("F_busy_done");
        put(1'b0, 0, 16'h0);
        check_value("F_lat_len", 32'(lat_last), 32'd4);
        check_value("F_word_count", 32'(cap_cnt - base), 32'd360);
        check_words("F", base, 360, 3);
        check_value("err_total", 32'(err_seen), 32'd2);
        check_value("ovr_total", 32'(ovr_seen), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
